// File: rtl/nx_fifo_1r1w_hw_ctrl.sv
// Hardware-port controller for an indirect-access 1R1W FIFO RAM: pointers, RAM
// word count, read-latency tracking and an output skid buffer sized for RD_LAT.
module nx_fifo_1r1w_hw_ctrl #(
  parameter int unsigned N_DATA_BITS = 32,
  parameter int unsigned N_ENTRIES   = 16,
  parameter int unsigned RD_LAT      = 2
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       soft_clr,
  input  logic                                       wr_vld,
  input  logic [N_DATA_BITS-1:0]                     wr_dat,
  output logic                                       wr_rdy,
  output logic                                       rd_vld,
  output logic [N_DATA_BITS-1:0]                     rd_dat,
  input  logic                                       rd_rdy,
  output logic                                       hw_cs,
  output logic                                       hw_we,
  output logic                                       hw_re,
  output logic [$clog2(N_ENTRIES)-1:0]               hw_waddr,
  output logic [$clog2(N_ENTRIES)-1:0]               hw_raddr,
  output logic [N_DATA_BITS-1:0]                     hw_din,
  input  logic [N_DATA_BITS-1:0]                     hw_dout,
  input  logic                                       hw_yield,
  output logic [$clog2(N_ENTRIES+RD_LAT+2)-1:0]      occupancy,
  output logic                                       empty,
  output logic                                       full
);

  localparam int unsigned AW  = $clog2(N_ENTRIES);
  localparam int unsigned CW  = $clog2(N_ENTRIES + 1);
  localparam int unsigned OW  = $clog2(N_ENTRIES + RD_LAT + 2);
  localparam int unsigned BD  = RD_LAT + 1;
  localparam int unsigned BAW = $clog2(BD);
  localparam int unsigned BCW = $clog2(BD + 1);
  localparam int unsigned IW  = $clog2(RD_LAT + 1);
  localparam int unsigned SW  = $clog2(2 * RD_LAT + 3);

  logic [AW-1:0]          wptr, rptr;
  logic [CW-1:0]          mem_cnt;
  logic [RD_LAT-1:0]      rd_sr;
  logic [N_DATA_BITS-1:0] obuf [BD];
  logic [BAW-1:0]         bwp, brp;
  logic [BCW-1:0]         bcnt;
  logic [IW-1:0]          inflight;
  logic [SW-1:0]          slots_used;
  logic                   cap, pop, issue_ok;

  function automatic logic [AW-1:0] ram_inc(input logic [AW-1:0] p);
    return (p == AW'(N_ENTRIES - 1)) ? '0 : p + AW'(1);
  endfunction

  function automatic logic [BAW-1:0] buf_inc(input logic [BAW-1:0] p);
    return (p == BAW'(BD - 1)) ? '0 : p + BAW'(1);
  endfunction

  // Reads in flight = number of tags in the latency shift register.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < int'(RD_LAT); i++) begin
      inflight = inflight + IW'(rd_sr[i]);
    end
  end

  // A pop this cycle frees a buffer slot at the same edge, so it counts as credit.
  always_comb begin
    cap        = rd_sr[RD_LAT-1];
    rd_vld     = rst_n && (bcnt != '0);
    pop        = rd_vld && rd_rdy;
    slots_used = SW'(bcnt) + SW'(inflight);
    issue_ok   = (slots_used - SW'(pop)) < SW'(BD);
    full       = rst_n && (mem_cnt == CW'(N_ENTRIES));
    wr_rdy     = rst_n && !full && !hw_yield && !soft_clr;
    hw_we      = wr_vld && wr_rdy;
    hw_re      = rst_n && (mem_cnt != '0) && issue_ok && !hw_yield && !soft_clr;
    hw_cs      = hw_we | hw_re;
    hw_waddr   = wptr;
    hw_raddr   = rptr;
    hw_din     = rst_n ? wr_dat : '0;
    rd_dat     = rd_vld ? obuf[brp] : '0;
    occupancy  = OW'(mem_cnt) + OW'(inflight) + OW'(bcnt);
    empty      = (occupancy == '0);
  end

  // Control state; soft_clr drops everything, including tags of returning reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr    <= '0;
      rptr    <= '0;
      mem_cnt <= '0;
      rd_sr   <= '0;
      bwp     <= '0;
      brp     <= '0;
      bcnt    <= '0;
    end else if (soft_clr) begin
      wptr    <= '0;
      rptr    <= '0;
      mem_cnt <= '0;
      rd_sr   <= '0;
      bwp     <= '0;
      brp     <= '0;
      bcnt    <= '0;
    end else begin
      if (hw_we) wptr <= ram_inc(wptr);
      if (hw_re) rptr <= ram_inc(rptr);
      case ({hw_we, hw_re})
        2'b10:   mem_cnt <= mem_cnt + CW'(1);
        2'b01:   mem_cnt <= mem_cnt - CW'(1);
        default: mem_cnt <= mem_cnt;
      endcase
      rd_sr <= RD_LAT'({rd_sr, hw_re});
      if (cap) bwp <= buf_inc(bwp);
      if (pop) brp <= buf_inc(brp);
      case ({cap, pop})
        2'b10:   bcnt <= bcnt + BCW'(1);
        2'b01:   bcnt <= bcnt - BCW'(1);
        default: bcnt <= bcnt;
      endcase
    end
  end

  // Untagged hw_dout cycles carry software read data and are never stored.
  always_ff @(posedge clk) begin
    if (cap && !soft_clr) obuf[bwp] <= hw_dout;
  end

endmodule

// File: tb/tb_nx_fifo_1r1w_hw_ctrl.sv
// Bench for nx_fifo_1r1w_hw_ctrl: RAM model with latency and software-read noise,
// word-queue scoreboard, directed vector table, corner sequences and random traffic.
module tb_nx_fifo_1r1w_hw_ctrl;
  localparam int DW = 32;
  localparam int NE = 5;
  localparam int RL = 2;
  localparam int AW = $clog2(NE);
  localparam int OW = $clog2(NE + RL + 2);

  logic clk = 1'b0;
  logic rst_n, soft_clr, wr_vld, wr_rdy, rd_vld, rd_rdy;
  logic [DW-1:0] wr_dat, rd_dat, hw_din, hw_dout;
  logic hw_cs, hw_we, hw_re, hw_yield, empty, full;
  logic [AW-1:0] hw_waddr, hw_raddr;
  logic [OW-1:0] occupancy;

  always #5 clk = ~clk;

  nx_fifo_1r1w_hw_ctrl #(.N_DATA_BITS(DW), .N_ENTRIES(NE), .RD_LAT(RL)) dut (
    .clk(clk), .rst_n(rst_n), .soft_clr(soft_clr),
    .wr_vld(wr_vld), .wr_dat(wr_dat), .wr_rdy(wr_rdy),
    .rd_vld(rd_vld), .rd_dat(rd_dat), .rd_rdy(rd_rdy),
    .hw_cs(hw_cs), .hw_we(hw_we), .hw_re(hw_re),
    .hw_waddr(hw_waddr), .hw_raddr(hw_raddr), .hw_din(hw_din),
    .hw_dout(hw_dout), .hw_yield(hw_yield),
    .occupancy(occupancy), .empty(empty), .full(full)
  );

  // RAM wrapper model: fixed read latency; untagged cycles show software read data.
  logic [DW-1:0] ram [NE];
  logic [RL-1:0] rv = '0;
  logic [DW-1:0] rdat [RL];
  logic [DW-1:0] junk = '0;
  logic s_we = 1'b0, s_re = 1'b0;
  logic [AW-1:0] s_wa = '0, s_ra = '0;
  logic [DW-1:0] s_din = '0;

  always @(negedge clk) begin
    s_we = hw_we; s_re = hw_re; s_wa = hw_waddr; s_ra = hw_raddr; s_din = hw_din;
  end

  always @(posedge clk) begin
    if (s_we) ram[s_wa] <= s_din;
    rv      <= RL'({rv, s_re});
    rdat[0] <= ram[s_ra];
    for (int i = 1; i < RL; i++) rdat[i] <= rdat[i-1];
    junk    <= {16'hBAD0, 16'($urandom)};
  end

  assign hw_dout = rv[RL-1] ? rdat[RL-1] : junk;

  // Scoreboard: every word held in order, and issue cycle of words read from RAM.
  int n_chk = 0, n_pass = 0, cyc = 0;
  logic [DW-1:0] q [$];
  int iq [$];
  int ram_cnt = 0, wr_idx = 0, rd_idx = 0;
  logic obs_we, obs_re, obs_rdy, obs_vld, obs_cs, obs_pop;
  int obs_occ;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic model_reset();
    q.delete(); iq.delete(); ram_cnt = 0; wr_idx = 0; rd_idx = 0;
  endtask

  task automatic step();
    bit e_full, e_rdy, e_we, e_vld, e_pop, e_re;
    @(negedge clk);
    e_full = (ram_cnt == NE);
    e_rdy  = !e_full && !hw_yield && !soft_clr;
    e_we   = wr_vld && e_rdy;
    e_vld  = (iq.size() > 0) && (cyc >= iq[0] + RL + 1);
    e_pop  = e_vld && rd_rdy;
    e_re   = (ram_cnt > 0) && !hw_yield && !soft_clr && ((iq.size() - int'(e_pop)) < RL + 1);
    obs_we = hw_we; obs_re = hw_re; obs_rdy = wr_rdy; obs_vld = rd_vld;
    obs_cs = hw_cs; obs_pop = rd_vld && rd_rdy; obs_occ = int'(occupancy);
    chk("full", 32'(full), 32'(e_full));
    chk("wr_rdy", 32'(wr_rdy), 32'(e_rdy));
    chk("hw_we", 32'(hw_we), 32'(e_we));
    chk("hw_re", 32'(hw_re), 32'(e_re));
    chk("hw_cs", 32'(hw_cs), 32'(e_we | e_re));
    chk("rd_vld", 32'(rd_vld), 32'(e_vld));
    chk("occupancy", 32'(occupancy), 32'(q.size()));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    if (e_we) begin
      chk("hw_waddr", 32'(hw_waddr), 32'(wr_idx));
      chk("hw_din", hw_din, wr_dat);
    end
    if (e_re) chk("hw_raddr", 32'(hw_raddr), 32'(rd_idx));
    if (e_we && e_re) chk("addr_differ", 32'(hw_waddr != hw_raddr), 32'd1);
    if (e_pop) chk("rd_dat", rd_dat, q[0]);
    if (soft_clr) model_reset();
    else begin
      if (e_pop) begin void'(q.pop_front()); void'(iq.pop_front()); end
      if (e_we) begin q.push_back(wr_dat); ram_cnt++; wr_idx = (wr_idx + 1) % NE; end
      if (e_re) begin iq.push_back(cyc); ram_cnt--; rd_idx = (rd_idx + 1) % NE; end
    end
    cyc++;
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic wv, input logic y, input logic clr, input logic rr);
    wr_vld = wv; hw_yield = y; soft_clr = clr; rd_rdy = rr; wr_dat = $urandom;
  endtask

  task automatic check_reset();
    chk("rst_wr_rdy", 32'(wr_rdy), 0); chk("rst_rd_vld", 32'(rd_vld), 0);
    chk("rst_hw_cs", 32'(hw_cs), 0);   chk("rst_hw_we", 32'(hw_we), 0);
    chk("rst_hw_re", 32'(hw_re), 0);   chk("rst_waddr", 32'(hw_waddr), 0);
    chk("rst_raddr", 32'(hw_raddr), 0); chk("rst_occ", 32'(occupancy), 0);
    chk("rst_full", 32'(full), 0);     chk("rst_empty", 32'(empty), 1);
    chk("rst_rd_dat", rd_dat, 0);      chk("rst_hw_din", hw_din, 0);
  endtask

  task automatic flush();
    drive(1'b0, 1'b0, 1'b1, 1'b0); step();
  endtask

  task automatic stream(input bit with_yield);
    int nxt = 0, pops = 0, first = -1, last = -1, maxo = 0, k = 0;
    while (pops < 100 && k < 400) begin
      wr_vld = (nxt < 100); wr_dat = DW'(nxt); rd_rdy = 1'b1; soft_clr = 1'b0;
      hw_yield = with_yield && (k >= 40) && (k < 44);
      step();
      if (hw_yield) chk("yield_cs", 32'(obs_cs), 0);
      if (obs_we) nxt++;
      if (obs_pop) begin pops++; if (first < 0) first = k; last = k; end
      if (obs_occ > maxo) maxo = obs_occ;
      k++;
    end
    hw_yield = 1'b0;
    chk("stream_pops", 32'(pops), 100);
    if (!with_yield) begin
      chk("stream_startup", 32'(first), 32'(RL + 2));
      chk("stream_span", 32'(last - first), 99);
      chk("stream_occ_le4", 32'(maxo <= 4), 1);
    end
  endtask

  task automatic fill();
    int acc = 0;
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0); step();
      if (obs_we) acc++;
    end
    chk("fill_accepted", 32'(acc), 32'(NE + RL + 1));
    #2;
    chk("fill_full", 32'(full), 1); chk("fill_wr_rdy", 32'(wr_rdy), 0);
    chk("fill_occ", 32'(occupancy), 32'(NE + RL + 1));
  endtask

  typedef struct { int wv, y, clr, rr, e_rdy, e_we, e_re, e_vld, e_full, e_occ; } vec_t;
  vec_t tv [10];

  initial begin
    int pops;
    tv[0] = '{1, 0, 0, 0, 1, 1, 0, 0, 0, 0};
    tv[1] = '{1, 0, 0, 0, 1, 1, 1, 0, 0, 1};
    tv[2] = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 2};
    tv[3] = '{0, 0, 0, 0, 1, 0, 1, 0, 0, 2};
    tv[4] = '{0, 0, 0, 1, 1, 0, 0, 1, 0, 2};
    tv[5] = '{0, 0, 0, 1, 1, 0, 0, 0, 0, 1};
    tv[6] = '{0, 0, 0, 1, 1, 0, 0, 1, 0, 1};
    tv[7] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    tv[8] = '{1, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    tv[9] = '{1, 0, 0, 0, 1, 1, 0, 0, 0, 0};

    rst_n = 1'b0; wr_vld = 1'b1; wr_dat = 32'hA5A5_5A5A; rd_rdy = 1'b1;
    hw_yield = 1'b0; soft_clr = 1'b0;
    #12 check_reset();
    @(posedge clk); #1 rst_n = 1'b1;
    model_reset();

    for (int i = 0; i < 10; i++) begin
      drive(tv[i].wv != 0, tv[i].y != 0, tv[i].clr != 0, tv[i].rr != 0);
      step();
      chk($sformatf("vec%0d_wr_rdy", i), 32'(obs_rdy), 32'(tv[i].e_rdy));
      chk($sformatf("vec%0d_hw_we", i), 32'(obs_we), 32'(tv[i].e_we));
      chk($sformatf("vec%0d_hw_re", i), 32'(obs_re), 32'(tv[i].e_re));
      chk($sformatf("vec%0d_rd_vld", i), 32'(obs_vld), 32'(tv[i].e_vld));
      chk($sformatf("vec%0d_occ", i), 32'(obs_occ), 32'(tv[i].e_occ));
    end

    flush(); stream(1'b0);
    flush(); stream(1'b1);

    flush(); fill();
    pops = 0;
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b1); step();
      if (obs_pop) pops++;
    end
    chk("drain_pops", 32'(pops), 32'(NE + RL + 1));
    #2 chk("drain_empty", 32'(empty), 1);

    flush(); fill();
    drive(1'b0, 1'b0, 1'b0, 1'b1); step();
    drive(1'b1, 1'b0, 1'b0, 1'b1); step();
    #2 chk("flush_pre_occ", 32'(occupancy), 7);
    drive(1'b1, 1'b0, 1'b1, 1'b0); step();
    #2;
    chk("flush_occ", 32'(occupancy), 0); chk("flush_empty", 32'(empty), 1);
    chk("flush_rd_vld", 32'(rd_vld), 0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b1); step();
      chk("flush_late_data", 32'(obs_vld), 0);
    end

    for (int i = 0; i < 1500; i++) begin
      wr_vld   = ($urandom_range(0, 99) < 70);
      rd_rdy   = ($urandom_range(0, 99) < 60);
      hw_yield = ($urandom_range(0, 99) < 12);
      soft_clr = ($urandom_range(0, 99) < 2);
      wr_dat   = $urandom;
      step();
    end

    drive(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step();
    rst_n = 1'b0;
    #1 check_reset();
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    model_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b1); step();
    chk("post_reset_wr_rdy", 32'(obs_rdy), 1);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
